// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package   : irq_pkg
// Purpose   : Shared constants for the interrupt source stage. It defines the
//             request codes seen by the processors, the FSM state encodings,
//             the interrupt source tag and the space-bar key code.
// Ports     : none
// Revision  : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Request codes on INT_IRQ. 2'b10 is reserved and never driven.
  localparam logic [1:0] IRQ_FRAME = 2'b00;
  localparam logic [1:0] IRQ_KEY   = 2'b01;
  localparam logic [1:0] IRQ_NONE  = 2'b11;

  // Key code the processors treat as the space bar.
  localparam logic [7:0] KEY_SPACE = 8'h20;

  // Handshake FSM encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ASSERT  = 2'd1;
  localparam state_t ST_SERVICE = 2'd2;

  // Source of the interrupt currently in flight.
  typedef enum logic {
    SRC_FRAME = 1'b0,
    SRC_KEY   = 1'b1
  } src_t;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : irq_controller_if
// Purpose   : Interrupt handshake between the source stage and a processor.
// Signals   : INT_IRQ  [1:0] request code (controller -> processor)
//             KBD_KEY  [7:0] key FIFO head (controller -> processor)
//             INT_BUSY       handshake in progress (controller -> processor)
//             INT_IACK       acknowledge pulse (processor -> controller)
//             INT_IEND       end-of-service pulse (processor -> controller)
// Modports  : master = interrupt controller, slave = processor
// Revision  : 1.0 - initial release
// ============================================================================
interface irq_controller_if;

  logic [1:0] INT_IRQ;
  logic [7:0] KBD_KEY;
  logic       INT_BUSY;
  logic       INT_IACK;
  logic       INT_IEND;

  modport master (
    output INT_IRQ,
    output KBD_KEY,
    output INT_BUSY,
    input  INT_IACK,
    input  INT_IEND
  );

  modport slave (
    input  INT_IRQ,
    input  KBD_KEY,
    input  INT_BUSY,
    output INT_IACK,
    output INT_IEND
  );

endinterface : irq_controller_if
`default_nettype wire

// File: rtl/irq_controller_key_fifo.sv
`default_nettype none
// ============================================================================
// Module    : key_fifo
// Purpose   : Small synchronous FIFO with a combinational head output.
//             A push while full is accepted only if a pop frees a slot in
//             the same cycle. Head reads as zero when the FIFO is empty.
// Ports     : clk, rst_n (async, active low)
//             push, push_data   write request and data
//             pop               read request (ignored when empty)
//             head              current oldest entry, 0 when empty
//             full, empty       occupancy flags
// Revision  : 1.0 - initial release
// ============================================================================
module key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : key_fifo
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module    : irq_controller
// Purpose   : Interrupt source stage. Collects frame ticks and key events,
//             buffers keys, arbitrates (frame before key) and runs the
//             IRQ / IACK / IEND handshake with an optional timeout.
// Ports     : CLK, RESET (async, active low)
//             FRAME_TICK          frame pulse from video timing
//             KBD_VALID, KBD_DATA key event from keyboard decoder
//             KBD_DROP            pulse when a key is lost to a full FIFO
//             FRAME_OVR           saturating count of coalesced frame ticks
//             bus                 handshake interface (master side)
// Revision  : 1.0 - initial release
// ============================================================================
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FRAME_TICK,
  input  logic                KBD_VALID,
  input  logic [7:0]          KBD_DATA,
  output logic                KBD_DROP,
  output logic [7:0]          FRAME_OVR,
  irq_controller_if.master    bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TMO_END = (CW+1)'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  src_t        src, src_next;
  logic [1:0]  irq_q, irq_next;
  logic [CW:0] tmo_cnt;
  logic        tmo_hit;
  logic        iack_frame;
  logic        iack_key;
  logic        frame_pend;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_key_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (KBD_VALID),
    .push_data (KBD_DATA),
    .pop       (iack_key),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.KBD_KEY = fifo_head;
  assign bus.INT_IRQ = irq_q;
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && ((tmo_cnt + (CW+1)'(1)) == TMO_END);

  // Drop pulse: a push was refused because no pop freed a slot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      KBD_DROP <= 1'b0;
    end else begin
      KBD_DROP <= KBD_VALID && fifo_full && !iack_key;
    end
  end

  // Frame pending flag. A tick coincident with its own acknowledge keeps
  // the flag set and is not counted as an overrun.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      frame_pend <= 1'b0;
      FRAME_OVR  <= 8'h00;
    end else if (FRAME_TICK) begin
      frame_pend <= 1'b1;
      if (frame_pend && !iack_frame && (FRAME_OVR != 8'hFF)) begin
        FRAME_OVR <= FRAME_OVR + 8'h01;
      end
    end else if (iack_frame) begin
      frame_pend <= 1'b0;
    end
  end

  // FSM state register, including the registered request code and the
  // timeout counter that restarts on every state change.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      src     <= SRC_FRAME;
      irq_q   <= IRQ_NONE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      src   <= src_next;
      irq_q <= irq_next;
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + (CW+1)'(1);
      end
    end
  end

  // FSM next-state logic. IEND is only looked at in SERVICE, so an IEND
  // arriving together with IACK is ignored.
  always_comb begin
    state_next = state;
    src_next   = src;
    irq_next   = irq_q;
    iack_frame = 1'b0;
    iack_key   = 1'b0;
    case (state)
      ST_IDLE: begin
        irq_next = IRQ_NONE;
        if (frame_pend) begin
          src_next   = SRC_FRAME;
          irq_next   = IRQ_FRAME;
          state_next = ST_ASSERT;
        end else if (!fifo_empty) begin
          src_next   = SRC_KEY;
          irq_next   = IRQ_KEY;
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (bus.INT_IACK) begin
          iack_frame = (src == SRC_FRAME);
          iack_key   = (src == SRC_KEY);
          irq_next   = IRQ_NONE;
          state_next = ST_SERVICE;
        end else if (tmo_hit) begin
          irq_next   = IRQ_NONE;
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.INT_IEND || tmo_hit) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        irq_next   = IRQ_NONE;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM output decode.
  always_comb begin
    bus.INT_BUSY = (state == ST_ASSERT) || (state == ST_SERVICE);
  end

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module    : tb_irq_controller
// Purpose   : Directed self-checking bench for irq_controller. One instance
//             runs with the timeout disabled, a second with an 8-cycle
//             timeout; both share the event inputs and reset.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_irq_controller;
  import irq_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FRAME_TICK;
  logic       KBD_VALID;
  logic [7:0] KBD_DATA;
  logic       drop_m, drop_t;
  logic [7:0] ovr_m, ovr_t;

  int total = 0;
  int bad   = 0;

  irq_controller_if ifm ();
  irq_controller_if ift ();

  irq_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FRAME_TICK (FRAME_TICK),
    .KBD_VALID  (KBD_VALID),
    .KBD_DATA   (KBD_DATA),
    .KBD_DROP   (drop_m),
    .FRAME_OVR  (ovr_m),
    .bus        (ifm.master)
  );

  irq_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut_to (
    .CLK        (CLK),
    .RESET      (RESET),
    .FRAME_TICK (FRAME_TICK),
    .KBD_VALID  (KBD_VALID),
    .KBD_DATA   (KBD_DATA),
    .KBD_DROP   (drop_t),
    .FRAME_OVR  (ovr_t),
    .bus        (ift.master)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic iack();
    ifm.INT_IACK = 1'b1;
    step();
    ifm.INT_IACK = 1'b0;
  endtask

  task automatic iend();
    ifm.INT_IEND = 1'b1;
    step();
    ifm.INT_IEND = 1'b0;
  endtask

  task automatic frame();
    FRAME_TICK = 1'b1;
    step();
    FRAME_TICK = 1'b0;
  endtask

  task automatic key(input logic [7:0] code);
    KBD_VALID = 1'b1;
    KBD_DATA  = code;
    step();
    KBD_VALID = 1'b0;
  endtask

  logic [7:0] drain [4];

  initial begin
    RESET        = 1'b0;
    FRAME_TICK   = 1'b0;
    KBD_VALID    = 1'b0;
    KBD_DATA     = 8'h00;
    ifm.INT_IACK = 1'b0;
    ifm.INT_IEND = 1'b0;
    ift.INT_IACK = 1'b0;
    ift.INT_IEND = 1'b0;
    drain[0] = 8'h02; drain[1] = 8'h03; drain[2] = 8'h04; drain[3] = 8'h06;

    repeat (3) step();
    chk("rst_irq",  ifm.INT_IRQ,  IRQ_NONE);
    chk("rst_key",  ifm.KBD_KEY,  8'h00);
    chk("rst_drop", drop_m,       1'b0);
    chk("rst_ovr",  ovr_m,        8'h00);
    chk("rst_busy", ifm.INT_BUSY, 1'b0);
    RESET = 1'b1;
    step();

    // Frame handshake: two-cycle latency, IACK drops request, IEND frees.
    frame();
    chk("frm_lat1", ifm.INT_IRQ, IRQ_NONE);
    step();
    chk("frm_irq",  ifm.INT_IRQ,  IRQ_FRAME);
    chk("frm_busy", ifm.INT_BUSY, 1'b1);
    iack();
    chk("frm_ack_irq",  ifm.INT_IRQ,  IRQ_NONE);
    chk("frm_ack_busy", ifm.INT_BUSY, 1'b1);
    step();
    step();
    iend();
    chk("frm_end_busy", ifm.INT_BUSY, 1'b0);
    chk("frm_end_irq",  ifm.INT_IRQ,  IRQ_NONE);

    // Two keys in back-to-back cycles.
    KBD_VALID = 1'b1;
    KBD_DATA  = KEY_SPACE;
    step();
    KBD_DATA  = 8'h41;
    step();
    KBD_VALID = 1'b0;
    chk("k1_irq", ifm.INT_IRQ, IRQ_KEY);
    ifm.INT_IACK = 1'b1;
    chk("k1_key_iack", ifm.KBD_KEY, 8'h20);
    step();
    ifm.INT_IACK = 1'b0;
    chk("k1_ack_irq", ifm.INT_IRQ, IRQ_NONE);
    chk("k1_advance", ifm.KBD_KEY, 8'h41);
    iend();
    step();
    chk("k2_irq", ifm.INT_IRQ, IRQ_KEY);
    chk("k2_key", ifm.KBD_KEY, 8'h41);
    iack();
    chk("k2_empty", ifm.KBD_KEY, 8'h00);
    chk("k2_ack_irq", ifm.INT_IRQ, IRQ_NONE);
    iend();

    // Frame and key in the same cycle: frame wins.
    FRAME_TICK = 1'b1;
    KBD_VALID  = 1'b1;
    KBD_DATA   = 8'h31;
    step();
    FRAME_TICK = 1'b0;
    KBD_VALID  = 1'b0;
    step();
    chk("arb_frame", ifm.INT_IRQ, IRQ_FRAME);
    chk("arb_key_hold", ifm.KBD_KEY, 8'h31);
    iack();
    iend();
    step();
    chk("arb_key_irq", ifm.INT_IRQ, IRQ_KEY);
    chk("arb_key_val", ifm.KBD_KEY, 8'h31);
    iack();
    iend();

    // Coalesced frame ticks and a tick coincident with IACK.
    frame();
    step();
    frame();
    step();
    frame();
    chk("ovr_cnt", ovr_m, 8'd2);
    chk("ovr_irq", ifm.INT_IRQ, IRQ_FRAME);
    FRAME_TICK   = 1'b1;
    ifm.INT_IACK = 1'b1;
    step();
    FRAME_TICK   = 1'b0;
    ifm.INT_IACK = 1'b0;
    chk("ovr_coinc_cnt", ovr_m, 8'd2);
    chk("ovr_coinc_irq", ifm.INT_IRQ, IRQ_NONE);
    iend();
    step();
    chk("ovr_reassert", ifm.INT_IRQ, IRQ_FRAME);
    iack();
    iend();
    step();
    chk("ovr_cleared", ifm.INT_IRQ, IRQ_NONE);
    chk("ovr_final", ovr_m, 8'd2);

    // Overflow: fifth key dropped; push with pop while full accepted.
    for (int i = 1; i <= 5; i++) begin
      KBD_VALID = 1'b1;
      KBD_DATA  = 8'(i);
      step();
      if (i == 4) chk("drop_early", drop_m, 1'b0);
    end
    KBD_VALID = 1'b0;
    chk("drop_pulse", drop_m, 1'b1);
    step();
    chk("drop_clear", drop_m, 1'b0);
    chk("full_irq", ifm.INT_IRQ, IRQ_KEY);
    chk("full_head", ifm.KBD_KEY, 8'h01);
    KBD_VALID    = 1'b1;
    KBD_DATA     = 8'h06;
    ifm.INT_IACK = 1'b1;
    step();
    KBD_VALID    = 1'b0;
    ifm.INT_IACK = 1'b0;
    chk("pushpop_nodrop", drop_m, 1'b0);
    chk("pushpop_head", ifm.KBD_KEY, 8'h02);
    iend();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_irq", ifm.INT_IRQ, IRQ_KEY);
      chk("drain_key", ifm.KBD_KEY, drain[i]);
      iack();
      iend();
    end
    chk("drain_empty", ifm.KBD_KEY, 8'h00);

    // Timeout instance: key asserted, never acknowledged.
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    key(8'h55);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) chk("tmo_irq_on", ift.INT_IRQ, IRQ_KEY);
      if (k == 8) begin
        chk("tmo_irq_last", ift.INT_IRQ, IRQ_KEY);
        chk("tmo_busy_last", ift.INT_BUSY, 1'b1);
      end
    end
    step();
    chk("tmo_idle_irq", ift.INT_IRQ, IRQ_NONE);
    chk("tmo_idle_busy", ift.INT_BUSY, 1'b0);
    chk("tmo_key_kept", ift.KBD_KEY, 8'h55);
    step();
    chk("tmo_reassert", ift.INT_IRQ, IRQ_KEY);

    // Asynchronous reset while in SERVICE.
    key(8'h66);
    chk("svc_pre_key", ifm.KBD_KEY, 8'h55);
    iack();
    frame();
    frame();
    chk("svc_busy", ifm.INT_BUSY, 1'b1);
    chk("svc_ovr",  ovr_m, 8'd1);
    chk("svc_key",  ifm.KBD_KEY, 8'h66);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_irq",  ifm.INT_IRQ,  IRQ_NONE);
    chk("arst_key",  ifm.KBD_KEY,  8'h00);
    chk("arst_busy", ifm.INT_BUSY, 1'b0);
    chk("arst_ovr",  ovr_m,        8'h00);
    chk("arst_drop", drop_m,       1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_irq_controller
`default_nettype wire
